// File: rtl/gbf_in_port_arbiter_if.sv
// Bus bundle between the input-GBF port arbiter, its requesters and the quad-port RAM.
//   req_*  : per-requester request/grant handshake (packed, requester i at slice i)
//   rsp_*  : registered read return per requester
//   ram_*  : ports A..D of the buffer RAM (ram_q is the combinational read data)
// master : environment side (requesters + RAM); slave : the arbiter.
interface gbf_in_port_arbiter_if #(
  parameter int unsigned NREQ  = 6,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 6
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ*WIDTH-1:0] rsp_rdata;
  logic [3:0]            ram_we;
  logic [4*AW-1:0]       ram_addr;
  logic [4*WIDTH-1:0]    ram_wdata;
  logic [4*WIDTH-1:0]    ram_q;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_q,
    input  req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_q,
    output req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/gbf_in_port_arbiter.sv
// Round-robin arbiter sharing the four ports of the input global buffer among
// NREQ requesters. Up to four grants per cycle, mapped in scan order onto ports
// A..D; a request that would write, or read, an address already written by an
// earlier grant this cycle is skipped without consuming a port. Read data is
// registered back to the requester one cycle after its grant.
// Ports: clk, rst_n (async, active low), bus (slave modport of
// gbf_in_port_arbiter_if), stall_cnt (saturating count of stalled cycles).
module gbf_in_port_arbiter #(
  parameter int unsigned NREQ   = 6,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned HEIGHT = 48,
  parameter int unsigned AW     = $clog2(HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gbf_in_port_arbiter_if.slave  bus,
  output logic [15:0]           stall_cnt
);

  localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NPORT = 4;

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    rr_next;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  rd_gnt;
  logic [NREQ-1:0]  ready_c;
  logic             stall_c;
  logic [NREQ-1:0]  rsp_valid_q;

  logic [AW-1:0]    addr_a  [NREQ];
  logic [WIDTH-1:0] wdata_a [NREQ];
  logic [WIDTH-1:0] rdata_q [NREQ];
  logic [WIDTH-1:0] rdata_n [NREQ];

  logic [NPORT-1:0] port_used;
  logic [NPORT-1:0] port_we;
  logic [AW-1:0]    port_addr  [NPORT];
  logic [WIDTH-1:0] port_wdata [NPORT];
  logic [PW-1:0]    port_src   [NPORT];

  // Unpack the per-requester request fields.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i]  = bus.req_addr[i*AW +: AW];
      wdata_a[i] = bus.req_wdata[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin scan: grant in order from rr_ptr, skipping same-address write hazards.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] sel;
    logic [2:0]    nport;
    logic          conflict;
    gnt        = '0;
    port_used  = '0;
    port_we    = '0;
    rr_next    = rr_ptr;
    nport      = 3'd0;
    sum        = '0;
    sel        = '0;
    conflict   = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      port_addr[k]  = '0;
      port_wdata[k] = '0;
      port_src[k]   = '0;
    end
    for (int j = 0; j < NREQ; j++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(j);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      sel = sum[PW-1:0];
      // Reads and writes alike must not touch an address already written this cycle.
      conflict = 1'b0;
      for (int k = 0; k < NPORT; k++) begin
        if (port_used[k] && port_we[k] && (port_addr[k] == addr_a[sel])) conflict = 1'b1;
      end
      if (bus.req_valid[sel] && (nport < 3'd4) && !conflict) begin
        gnt[sel]                 = 1'b1;
        port_used[nport[1:0]]    = 1'b1;
        port_we[nport[1:0]]      = bus.req_we[sel];
        port_addr[nport[1:0]]    = addr_a[sel];
        port_wdata[nport[1:0]]   = wdata_a[sel];
        port_src[nport[1:0]]     = sel;
        nport                    = nport + 3'd1;
        rr_next                  = (sel == PW'(NREQ-1)) ? '0 : sel + 1'b1;
      end
    end
  end

  // Grants and RAM writes are suppressed while reset is asserted.
  assign ready_c       = gnt & {NREQ{rst_n}};
  assign bus.req_ready = ready_c;
  assign bus.ram_we    = port_we & port_used & {NPORT{rst_n}};
  assign stall_c       = |(bus.req_valid & ~ready_c);

  for (genvar g = 0; g < NPORT; g++) begin : g_port
    assign bus.ram_addr[g*AW +: AW]        = port_addr[g];
    assign bus.ram_wdata[g*WIDTH +: WIDTH] = port_wdata[g];
  end

  // Route each granted read's port data back to its requester.
  always_comb begin
    rd_gnt  = '0;
    rdata_n = rdata_q;
    for (int k = 0; k < NPORT; k++) begin
      if (port_used[k] && !port_we[k]) begin
        rd_gnt[port_src[k]]  = 1'b1;
        rdata_n[port_src[k]] = bus.ram_q[k*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_rsp
    assign bus.rsp_rdata[g*WIDTH +: WIDTH] = rdata_q[g];
  end
  assign bus.rsp_valid = rsp_valid_q;

  // Pointer, response and stall counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      rsp_valid_q <= '0;
      stall_cnt   <= '0;
      for (int i = 0; i < NREQ; i++) rdata_q[i] <= '0;
    end else begin
      rr_ptr      <= rr_next;
      rsp_valid_q <= rd_gnt;
      rdata_q     <= rdata_n;
      if (stall_c && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
